// File: rtl/toggle_ctrl_pkg.sv
// Shared definitions for button-driven control blocks: FSM encodings,
// default debounce/repeat timing and the counter-width helper.
package toggle_ctrl_pkg;

  localparam logic [1:0] ST_IDLE_ENC         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT_ENC   = 2'd1;
  localparam logic [1:0] ST_HELD_ENC         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE         = ST_IDLE_ENC,
    ST_PRESS_WAIT   = ST_PRESS_WAIT_ENC,
    ST_HELD         = ST_HELD_ENC,
    ST_RELEASE_WAIT = ST_RELEASE_WAIT_ENC
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 500;
  localparam int DEF_REPEAT_PERIOD   = 100;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Wide enough to hold the largest terminal count without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c) + 1);
  endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level; resets to 0.
module input_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_pulse_debouncer.sv
// Turns a raw bouncing button into one clean t_pulse per accepted press,
// with optional hold-to-repeat, for driving a downstream T flip-flop.
module toggle_pulse_debouncer
  import toggle_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 0,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       en,
  output logic       t_pulse,
  output logic       btn_state,
  output logic       repeat_active,
  output logic [1:0] dbg_state
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] RD_MAX = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RP_MAX = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic          REP    = (REPEAT_EN != 0);
  localparam logic          POL    = (ACTIVE_LOW != 0);

  // Valid/ready does not apply here: t_pulse is a one-cycle strobe with no
  // back-pressure; the consumer must act on it in the cycle it is high.

  logic          s_raw;
  logic          s;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rcnt;
  logic          use_period;
  logic          rep_due;

  // Polarity is corrected ahead of the chain so that reset (all 0) means released.
  input_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in ^ POL),
    .q  (s_raw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= 1'b0;
    end else begin
      s <= s_raw;
    end
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + ONE;
  endfunction

  // rcnt counts cycles since the last pulse; the first repeat waits the
  // longer delay, later ones (and any after a release bounce) the period.
  always_comb begin
    rep_due = 1'b0;
    if (REP) begin
      rep_due = use_period ? (rcnt >= RP_MAX) : (rcnt >= RD_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      rcnt          <= '0;
      use_period    <= 1'b0;
      t_pulse       <= 1'b0;
      btn_state     <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      t_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (s) begin
            state <= ST_PRESS_WAIT;
            cnt   <= ONE;
          end
        end

        ST_PRESS_WAIT: begin
          if (!s) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt >= DB_MAX) begin
            state      <= ST_HELD;
            cnt        <= '0;
            rcnt       <= REP ? ONE : '0;
            use_period <= 1'b0;
            t_pulse    <= en;
            btn_state  <= 1'b1;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        ST_HELD: begin
          cnt <= '0;
          if (!s) begin
            state         <= ST_RELEASE_WAIT;
            cnt           <= ONE;
            rcnt          <= '0;
            use_period    <= 1'b0;
            repeat_active <= 1'b0;
          end else if (rep_due) begin
            t_pulse       <= en;
            rcnt          <= ONE;
            use_period    <= 1'b1;
            repeat_active <= 1'b1;
          end else if (REP) begin
            rcnt <= sat_inc(rcnt);
          end
        end

        ST_RELEASE_WAIT: begin
          if (s) begin
            state      <= ST_HELD;
            cnt        <= '0;
            rcnt       <= REP ? ONE : '0;
            use_period <= REP;
          end else if (cnt >= DB_MAX) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            btn_state <= 1'b0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          rcnt  <= '0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule
